sync_ram_ctrl: RTL and testbench

Parametrised single-port synchronous RAM with a valid/ready request channel and a valid/ready response channel. It supports byte-enable writes, a selectable read latency of 1 or 2 cycles, and out-of-range address detection. After every reset it runs a hardware clear of the whole array. It replaces the raw tri-state cs/we/oe RAM wherever a pipelined master (core load/store unit, DMA) needs backpressure-safe memory.

---
 rtl/sync_ram_ctrl_if.sv | 28 ++
 rtl/sync_ram_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_sync_ram_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_ram_ctrl_if.sv
// Request/response channel bundle for sync_ram_ctrl.
// The master drives requests and rsp_ready; the slave (the RAM block) drives
// req_ready and the response fields.
interface sync_ram_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
);
  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [DATA_W/8-1:0] req_be;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sync_ram_ctrl.sv
// Single-port synchronous RAM with valid/ready request and response channels,
// byte-enable writes, read latency of 1 or 2 cycles, out-of-range detection
// and a one-word-per-cycle hardware clear after every reset.
//
// Response path: the array is read on the accept edge. For RD_LAT=2 the
// result passes through one extra stage register. Responses then enter the
// output side: a registered output slot backed by a two-entry skid FIFO, which
// together absorb every outstanding response while rsp_ready is low.
module sync_ram_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 60,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  sync_ram_ctrl_if.slave bus,
  output logic           init_done
);

  localparam int                BE_W      = DATA_W / 8;
  localparam logic [1:0]        CAP       = 2'(RD_LAT + 1);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
  localparam logic [DATA_W-1:0] ZERO_W    = {DATA_W{1'b0}};

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   clr_addr_r;
  logic                clr_we_s;
  logic                init_done_r;
  logic [DATA_W-1:0]   mem_r [DEPTH];

  logic                req_ready_s;
  logic                accept_s;
  logic                in_range_s;
  logic [DATA_W-1:0]   new_data_s;

  logic                stage_valid_r;
  logic [DATA_W-1:0]   stage_data_r;
  logic                stage_err_r;

  logic                arr_valid_s;
  logic [DATA_W-1:0]   arr_data_s;
  logic                arr_err_s;

  logic [DATA_W-1:0]   fifo_data_r [2];
  logic                fifo_err_r  [2];
  logic                fifo_wp_r;
  logic                fifo_rp_r;
  logic [1:0]          fifo_cnt_r;
  logic                fifo_empty_s;
  logic                fifo_push_s;
  logic                fifo_pop_s;

  logic                rsp_valid_r;
  logic [DATA_W-1:0]   rsp_rdata_r;
  logic                rsp_err_r;
  logic                deliver_s;
  logic                out_free_s;
  logic                out_load_s;
  logic [1:0]          outstanding_r;

  assign accept_s     = bus.req_valid && req_ready_s;
  assign in_range_s   = ({1'b0, bus.req_addr} < DEPTH_X);
  assign deliver_s    = rsp_valid_r && bus.rsp_ready;
  assign out_free_s   = !rsp_valid_r || deliver_s;
  assign fifo_empty_s = (fifo_cnt_r == 2'd0);
  assign out_load_s   = out_free_s && (!fifo_empty_s || arr_valid_s);
  assign fifo_pop_s   = out_free_s && !fifo_empty_s;
  assign fifo_push_s  = arr_valid_s && !(out_free_s && fifo_empty_s);

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;
  assign init_done     = init_done_r;

  // Sequencer state, clear pointer and init_done flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_CLEAR;
      clr_addr_r  <= {ADDR_W{1'b0}};
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      init_done_r <= (state_nxt_s == ST_RUN);
      if (clr_we_s) begin
        clr_addr_r <= clr_addr_r + ONE_A;
      end
    end
  end

  // Next-state and request-acceptance decode for the clear/run sequencer.
  always_comb begin
    state_nxt_s = state_r;
    clr_we_s    = 1'b0;
    req_ready_s = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        clr_we_s = 1'b1;
        if (clr_addr_r == LAST_ADDR) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_RUN: begin
        req_ready_s = !rst && (outstanding_r < CAP);
      end
      default: begin
        state_nxt_s = ST_CLEAR;
      end
    endcase
  end

  // Storage array: clear sweep, then byte-masked writes; untouched while rst is held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we_s) begin
        mem_r[clr_addr_r] <= ZERO_W;
      end else if (accept_s && bus.req_we && in_range_s) begin
        for (int i = 0; i < BE_W; i++) begin
          if (bus.req_be[i]) begin
            mem_r[bus.req_addr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
          end
        end
      end
    end
  end

  // Response data for the request being accepted: reads of valid words only.
  always_comb begin
    new_data_s = ZERO_W;
    if (!bus.req_we && in_range_s) begin
      new_data_s = mem_r[bus.req_addr];
    end else begin
      new_data_s = ZERO_W;
    end
  end

  // Pick what reaches the output side this edge: the fresh read or the extra stage.
  always_comb begin
    arr_valid_s = 1'b0;
    arr_data_s  = ZERO_W;
    arr_err_s   = 1'b0;
    if (RD_LAT == 1) begin
      arr_valid_s = accept_s;
      arr_data_s  = new_data_s;
      arr_err_s   = !in_range_s;
    end else begin
      arr_valid_s = stage_valid_r;
      arr_data_s  = stage_data_r;
      arr_err_s   = stage_err_r;
    end
  end

  // Latency stage, skid FIFO, registered response outputs and outstanding count.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid_r <= 1'b0;
      stage_data_r  <= ZERO_W;
      stage_err_r   <= 1'b0;
      fifo_wp_r     <= 1'b0;
      fifo_rp_r     <= 1'b0;
      fifo_cnt_r    <= 2'd0;
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= ZERO_W;
      rsp_err_r     <= 1'b0;
      outstanding_r <= 2'd0;
    end else begin
      stage_valid_r <= accept_s;
      if (accept_s) begin
        stage_data_r <= new_data_s;
        stage_err_r  <= !in_range_s;
      end
      if (fifo_push_s) begin
        fifo_data_r[fifo_wp_r] <= arr_data_s;
        fifo_err_r[fifo_wp_r]  <= arr_err_s;
        fifo_wp_r              <= !fifo_wp_r;
      end
      if (fifo_pop_s) begin
        fifo_rp_r <= !fifo_rp_r;
      end
      fifo_cnt_r <= fifo_cnt_r + {1'b0, fifo_push_s} - {1'b0, fifo_pop_s};
      // The oldest response always sits in the output slot; data holds otherwise.
      if (out_load_s) begin
        rsp_valid_r <= 1'b1;
        if (!fifo_empty_s) begin
          rsp_rdata_r <= fifo_data_r[fifo_rp_r];
          rsp_err_r   <= fifo_err_r[fifo_rp_r];
        end else begin
          rsp_rdata_r <= arr_data_s;
          rsp_err_r   <= arr_err_s;
        end
      end else if (deliver_s) begin
        rsp_valid_r <= 1'b0;
      end
      outstanding_r <= outstanding_r + {1'b0, accept_s} - {1'b0, deliver_s};
    end
  end

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// Self-checking bench for sync_ram_ctrl. Two instances (RD_LAT=1 and 2) share
// the stimulus; sel routes requests to one of them at a time and muxes its
// outputs back. A behavioural model (word array + expected-response queue)
// predicts every response from the handshake rules.
module tb_sync_ram_ctrl;
  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int DEPTH = 60;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, sel, req_valid, req_we, rsp_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_be;
  logic          init_done1, init_done2;

  sync_ram_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
  sync_ram_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();

  assign bus1.req_valid = req_valid & ~sel;
  assign bus1.req_we    = req_we;
  assign bus1.req_addr  = req_addr;
  assign bus1.req_wdata = req_wdata;
  assign bus1.req_be    = req_be;
  assign bus1.rsp_ready = rsp_ready & ~sel;
  assign bus2.req_valid = req_valid & sel;
  assign bus2.req_we    = req_we;
  assign bus2.req_addr  = req_addr;
  assign bus2.req_wdata = req_wdata;
  assign bus2.req_be    = req_be;
  assign bus2.rsp_ready = rsp_ready & sel;

  sync_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .init_done(init_done1));
  sync_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave), .init_done(init_done2));

  logic          m_req_ready, m_rsp_valid, m_rsp_err, m_init_done;
  logic [DW-1:0] m_rsp_rdata;
  assign m_req_ready = sel ? bus2.req_ready : bus1.req_ready;
  assign m_rsp_valid = sel ? bus2.rsp_valid : bus1.rsp_valid;
  assign m_rsp_err   = sel ? bus2.rsp_err   : bus1.rsp_err;
  assign m_rsp_rdata = sel ? bus2.rsp_rdata : bus1.rsp_rdata;
  assign m_init_done = sel ? init_done2     : init_done1;

  logic [DW-1:0] model_mem [64];
  logic [DW:0]   exp_q[$];
  logic [DW:0]   got_q[$];
  int            acc_cyc_q[$];
  int            dlv_cyc_q[$];
  int            cyc, lat, n_tests, n_fail;

  task automatic clear_sb();
    exp_q.delete(); got_q.delete(); acc_cyc_q.delete(); dlv_cyc_q.delete();
  endtask

  // One clock: predict the handshakes of the coming edge, update the model, advance.
  task automatic step();
    logic acc, dlv;
    acc = !rst && req_valid && m_req_ready;
    dlv = !rst && m_rsp_valid && rsp_ready;
    if (dlv) begin
      got_q.push_back({m_rsp_err, m_rsp_rdata});
      dlv_cyc_q.push_back(cyc);
    end
    if (acc) begin
      acc_cyc_q.push_back(cyc);
      if (int'(req_addr) >= DEPTH) begin
        exp_q.push_back({1'b1, 32'h0});
      end else if (req_we) begin
        for (int i = 0; i < 4; i++)
          if (req_be[i]) model_mem[req_addr][8*i +: 8] = req_wdata[8*i +: 8];
        exp_q.push_back({1'b0, 32'h0});
      end else begin
        exp_q.push_back({1'b0, model_mem[req_addr]});
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] d,
                      input logic [3:0] be);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = d; req_be = be;
    while (!m_req_ready && n < 100) begin step(); n++; end
    if (n >= 100) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: req_ready stayed 0 for %0d cycles, expected 1", n);
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic drain(output bit ok);
    int n = 0;
    req_valid = 1'b0; rsp_ready = 1'b1;
    while ((got_q.size() < exp_q.size() || m_rsp_valid) && n < 50) begin step(); n++; end
    ok = (n < 50);
  endtask

  task automatic do_reset(input int n, output int clr_cnt);
    req_valid = 1'b0; rst = 1'b1;
    repeat (n) step();
    clear_sb();
    rst = 1'b0; clr_cnt = 0;
    while (!m_req_ready && clr_cnt < 200) begin step(); clr_cnt++; end
    for (int a = 0; a < 64; a++) model_mem[a] = 32'h0;
  endtask

  task automatic read_all();
    rsp_ready = 1'b1;
    for (int a = 0; a < DEPTH; a++) send(1'b0, 6'(a), 32'h0, 4'h0);
  endtask

  task automatic test_reset();
    int clr, bad;
    bit ok;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    step(); step();
    n_tests++;
    if ({m_req_ready, m_rsp_valid, m_rsp_err, m_init_done} !== 4'b0 || m_rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy/vld/err/done=%b rdata=%h, expected 0000 and 0",
               {m_req_ready, m_rsp_valid, m_rsp_err, m_init_done}, m_rsp_rdata);
    end
    do_reset(0, clr);
    n_tests++;
    if (clr !== 60) begin n_fail++; $display("FAIL clear_cycles: got %0d, expected 60", clr); end
    n_tests++;
    if (m_init_done !== 1'b1) begin n_fail++; $display("FAIL init_done: got %b, expected 1", m_init_done); end
    rsp_ready = 1'b1;
    for (int a = 0; a < DEPTH; a++) send(1'b1, 6'(a), $urandom, 4'hF);
    drain(ok);
    do_reset(2, clr);
    n_tests++;
    if (clr !== 60) begin n_fail++; $display("FAIL clear_cycles_2: got %0d, expected 60", clr); end
    read_all();
    drain(ok);
    n_tests++;
    if (!ok || got_q.size() != DEPTH) begin
      n_fail++; $display("FAIL clear_reads: got %0d responses, expected %0d", got_q.size(), DEPTH);
    end else begin
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (got_q[i] !== 33'h0) bad++;
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL clear_zero: %0d nonzero words, expected 0", bad); end
    end
  endtask

  task automatic test_byte_enable();
    bit ok;
    clear_sb();
    rsp_ready = 1'b1;
    send(1'b1, 6'd5, 32'hDEADBEEF, 4'hF);
    send(1'b1, 6'd5, 32'h11223344, 4'b0101);
    send(1'b0, 6'd5, 32'h0, 4'h0);
    send(1'b1, 6'd5, 32'hFFFFFFFF, 4'h0);
    send(1'b0, 6'd5, 32'h0, 4'h0);
    drain(ok);
    n_tests++;
    if (!ok || got_q.size() != 5) begin
      n_fail++; $display("FAIL be_count: got %0d responses, expected 5", got_q.size());
    end else begin
      n_tests++;
      if (got_q[2] !== {1'b0, 32'hDE22BE44}) begin
        n_fail++; $display("FAIL be_merge: got %h, expected 0de22be44", got_q[2]);
      end
      n_tests++;
      if (got_q[4] !== {1'b0, 32'hDE22BE44}) begin
        n_fail++; $display("FAIL be_zero: got %h, expected 0de22be44", got_q[4]);
      end
      n_tests++;
      if (got_q[0] !== 33'h0) begin n_fail++; $display("FAIL wr_rsp: got %h, expected 0", got_q[0]); end
    end
  endtask

  task automatic test_throughput();
    bit ok;
    int stalls;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(1'b1, 6'(i), 32'h100 + i, 4'hF);
    drain(ok);
    clear_sb();
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 6'(i);
      if (!m_req_ready) stalls++;
      step();
    end
    req_valid = 1'b0;
    drain(ok);
    n_tests++;
    if (stalls != 0) begin n_fail++; $display("FAIL tput_ready: %0d stalled cycles, expected 0", stalls); end
    n_tests++;
    if (!ok || got_q.size() != 8) begin
      n_fail++; $display("FAIL tput_count: got %0d responses, expected 8", got_q.size());
    end else begin
      n_tests++;
      if (dlv_cyc_q[0] - acc_cyc_q[0] != lat) begin
        n_fail++; $display("FAIL tput_latency: got %0d, expected %0d", dlv_cyc_q[0] - acc_cyc_q[0], lat);
      end
      for (int i = 0; i < 8; i++) begin
        n_tests++;
        if (got_q[i] !== {1'b0, 32'h100 + i} || dlv_cyc_q[i] != dlv_cyc_q[0] + i) begin
          n_fail++; $display("FAIL tput_data[%0d]: got %h at +%0d, expected %h at +%0d",
                             i, got_q[i], dlv_cyc_q[i] - dlv_cyc_q[0], 32'h100 + i, i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok, have;
    int n_acc, unstable, bad;
    logic [DW:0] held;
    rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(1'b1, 6'(i), $urandom, 4'hF);
    drain(ok);
    clear_sb();
    rsp_ready = 1'b0; n_acc = 0; unstable = 0; have = 1'b0; held = 33'h0;
    for (int k = 0; k < 6; k++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 6'($urandom_range(0, 15));
      if (m_req_ready) n_acc++;
      if (m_rsp_valid) begin
        if (!have) begin have = 1'b1; held = {m_rsp_err, m_rsp_rdata}; end
        else if ({m_rsp_err, m_rsp_rdata} !== held) unstable++;
      end
      step();
    end
    req_valid = 1'b0;
    n_tests++;
    if (n_acc != lat + 1) begin n_fail++; $display("FAIL bp_accepts: got %0d, expected %0d", n_acc, lat + 1); end
    n_tests++;
    if (m_req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b, expected 0", m_req_ready); end
    n_tests++;
    if (!have || unstable != 0) begin
      n_fail++; $display("FAIL bp_stable: presented=%b changes=%0d, expected 1 and 0", have, unstable);
    end
    drain(ok);
    n_tests++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL bp_count: got %0d responses, expected %0d", got_q.size(), exp_q.size());
    end else begin
      bad = 0;
      for (int i = 0; i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL bp_order: %0d wrong responses, expected 0", bad); end
    end
  endtask

  task automatic test_range();
    bit ok;
    clear_sb();
    rsp_ready = 1'b1;
    send(1'b1, 6'd3, 32'hA5A55A5A, 4'hF);
    send(1'b0, 6'd60, 32'h0, 4'h0);
    send(1'b1, 6'd63, 32'hFFFFFFFF, 4'hF);
    send(1'b0, 6'd3, 32'h0, 4'h0);
    drain(ok);
    n_tests++;
    if (!ok || got_q.size() != 4) begin
      n_fail++; $display("FAIL range_count: got %0d responses, expected 4", got_q.size());
    end else begin
      n_tests++;
      if (got_q[1] !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL range_rd: got %h, expected 100000000", got_q[1]); end
      n_tests++;
      if (got_q[2] !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL range_wr: got %h, expected 100000000", got_q[2]); end
      n_tests++;
      if (got_q[3] !== {1'b0, 32'hA5A55A5A}) begin
        n_fail++; $display("FAIL range_alias: got %h, expected 0a5a55a5a", got_q[3]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int rdy_bad, bad;
    clear_sb();
    rdy_bad = 0;
    for (int k = 0; k < 300; k++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = ($urandom_range(0, 1) == 1);
      req_addr  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(60, 63)) : 6'($urandom_range(0, 15));
      req_wdata = $urandom;
      req_be    = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (m_req_ready !== ((exp_q.size() - got_q.size()) < lat + 1)) rdy_bad++;
      step();
    end
    drain(ok);
    n_tests++;
    if (rdy_bad != 0) begin n_fail++; $display("FAIL rand_ready: %0d wrong cycles, expected 0", rdy_bad); end
    n_tests++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d responses, expected %0d", got_q.size(), exp_q.size());
    end else begin
      bad = 0;
      for (int i = 0; i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL rand_data: %0d wrong responses, expected 0", bad); end
    end
  endtask

  task automatic test_reset_midstream();
    bit ok;
    int clr, bad;
    clear_sb();
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 6'(k + 1);
      step();
    end
    n_tests++;
    if (exp_q.size() != lat + 1) begin
      n_fail++; $display("FAIL mid_fill: %0d outstanding, expected %0d", exp_q.size(), lat + 1);
    end
    rst = 1'b1; req_valid = 1'b0;
    step();
    n_tests++;
    if (m_rsp_valid !== 1'b0 || m_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst: rsp_valid=%b req_ready=%b, expected 0 0", m_rsp_valid, m_req_ready);
    end
    rsp_ready = 1'b1;
    do_reset(0, clr);
    n_tests++;
    if (clr !== 60 || got_q.size() != 0) begin
      n_fail++; $display("FAIL mid_clear: %0d cycles %0d stale, expected 60 and 0", clr, got_q.size());
    end
    read_all();
    drain(ok);
    n_tests++;
    if (!ok || got_q.size() != DEPTH) begin
      n_fail++; $display("FAIL mid_reads: got %0d responses, expected %0d", got_q.size(), DEPTH);
    end else begin
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (got_q[i] !== 33'h0) bad++;
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL mid_zero: %0d nonzero words, expected 0", bad); end
    end
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    cyc = 0; lat = 1; n_tests = 0; n_fail = 0;
    for (int a = 0; a < 64; a++) model_mem[a] = 32'h0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      lat = s + 1;
      test_reset();
      test_byte_enable();
      test_throughput();
      test_backpressure();
      test_range();
      test_random();
      test_reset_midstream();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
